mdu_issue_ctrl: RTL and testbench

- Sequencing controller for the multiply/divide unit (MDU) in the five-stage MIPS pipeline.
- Decodes the MD op class of the instruction in EX and decides when a mult/div op is issued.
- Owns the multi-cycle latency counter: drives busy and the one-cycle HI/LO commit strobe to the MDU datapath.
- Generates the D-stage stall for any MD instruction that collides with an in-flight operation.

---
 rtl/mdu_pkg.sv | 30 +++
 rtl/mdu_issue_ctrl_if.sv | 21 ++
 rtl/mdu_issue_ctrl.sv | 83 ++++++++
 tb/tb_mdu_issue_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared MD op-code definitions for the MDU issue controller and datapath.
// Keeping the codes and class helpers here stops the two sides from drifting apart.
package mdu_pkg;

    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MFHI  = 4'd5;
    localparam logic [3:0] MD_MFLO  = 4'd6;
    localparam logic [3:0] MD_MTHI  = 4'd7;
    localparam logic [3:0] MD_MTLO  = 4'd8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mdu_state_e;

    // Ops that launch a multi-cycle MDU operation.
    function automatic logic is_start(input logic [3:0] op);
        return (op >= MD_MULT) && (op <= MD_DIVU);
    endfunction

    // Any op that touches HI/LO or the MDU; codes 9..15 count as none.
    function automatic logic is_md(input logic [3:0] op);
        return (op >= MD_MULT) && (op <= MD_MTLO);
    endfunction

endpackage

// File: rtl/mdu_issue_ctrl_if.sv
// Pipeline <-> MDU issue controller signal bundle.
// master: pipeline side (drives op codes), slave: the issue controller.
interface mdu_issue_ctrl_if;
    logic [3:0] d_md_op;
    logic [3:0] e_md_op;
    logic       e_cancel;
    logic       mdu_start;
    logic       mdu_hilo_we;
    logic       mdu_busy;
    logic       md_stall;

    modport master (
        output d_md_op, e_md_op, e_cancel,
        input  mdu_start, mdu_hilo_we, mdu_busy, md_stall
    );

    modport slave (
        input  d_md_op, e_md_op, e_cancel,
        output mdu_start, mdu_hilo_we, mdu_busy, md_stall
    );
endinterface

// File: rtl/mdu_issue_ctrl.sv
// MDU issue controller: decides when mult/div issues from EX, counts the
// multi-cycle latency, drives busy and the one-cycle HI/LO commit strobe,
// and stalls D for any MD instruction that would collide with an in-flight op.
// Optional macro MDU_CANCEL_EN: lets e_cancel kill a would-be issue in EX.
module mdu_issue_ctrl
    import mdu_pkg::*;
#(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic             clk,
    input  logic             reset,
    mdu_issue_ctrl_if.slave  md
);

    localparam logic [3:0] MULT_CNT = 4'(MULT_LAT - 1);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT - 1);

    mdu_state_e state_reg;
    logic [3:0] cnt_reg;
    logic       busy_reg;
    logic       hilo_we_reg;

    logic       ex_start;
    logic [3:0] cnt_load;

`ifdef MDU_CANCEL_EN
    // A cancelled EX op neither issues nor holds up D.
    assign ex_start = is_start(md.e_md_op) & ~md.e_cancel;
`else
    logic unused_cancel;
    assign unused_cancel = md.e_cancel;
    assign ex_start = is_start(md.e_md_op);
`endif

    // Initial count for the op being issued: divides take the long latency.
    assign cnt_load = ((md.e_md_op == MD_DIV) || (md.e_md_op == MD_DIVU)) ? DIV_CNT : MULT_CNT;

    // Start is gated by reset so nothing launches while the controller is held.
    assign md.mdu_start   = reset & (state_reg == IDLE) & ex_start;
    assign md.md_stall    = is_md(md.d_md_op) & (busy_reg | ex_start);
    assign md.mdu_busy    = busy_reg;
    assign md.mdu_hilo_we = hilo_we_reg;

    // Issue/latency FSM with registered busy and commit strobe.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg   <= IDLE;
            cnt_reg     <= 4'd0;
            busy_reg    <= 1'b0;
            hilo_we_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (ex_start) begin
                        state_reg   <= RUN;
                        busy_reg    <= 1'b1;
                        cnt_reg     <= cnt_load;
                        // A latency of one commits in the very first busy cycle.
                        hilo_we_reg <= (cnt_load == 4'd0);
                    end
                end
                RUN: begin
                    // Start requests seen here are illegal and deliberately ignored.
                    if (cnt_reg != 4'd0) begin
                        cnt_reg     <= cnt_reg - 4'd1;
                        hilo_we_reg <= (cnt_reg == 4'd1);
                    end else begin
                        state_reg   <= IDLE;
                        busy_reg    <= 1'b0;
                        hilo_we_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    busy_reg    <= 1'b0;
                    hilo_we_reg <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Directed bench for mdu_issue_ctrl (default latencies 5/10).
// Expectations for the cancel scenario follow MDU_CANCEL_EN.
module tb_mdu_issue_ctrl;
    import mdu_pkg::*;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    mdu_issue_ctrl_if bus();

    mdu_issue_ctrl #(.MULT_LAT(5), .DIV_LAT(10)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus must never present a start op in EX while an op is in flight.
    always @(negedge clk) begin
        if (reset === 1'b1 && bus.mdu_busy === 1'b1 && is_start(bus.e_md_op)) begin
            errors++;
            $display("FAIL protocol: e_md_op=%0d while busy, required no start op", bus.e_md_op);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] d, input logic [3:0] e, input logic c);
        bus.d_md_op  = d;
        bus.e_md_op  = e;
        bus.e_cancel = c;
        #2;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            drive(MD_NONE, MD_MULT, 1'b0);
            checks++;
            if (bus.mdu_start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b want 0", bus.mdu_start); end
            checks++;
            if (bus.mdu_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.mdu_busy); end
            checks++;
            if (bus.mdu_hilo_we !== 1'b0) begin errors++; $display("FAIL reset_hilo: got %b want 0", bus.mdu_hilo_we); end
        end
        tick();
        reset = 1'b1;
        drive(MD_NONE, MD_MULT, 1'b0);
        checks++;
        if (bus.mdu_start !== 1'b1) begin errors++; $display("FAIL rel_start: got %b want 1", bus.mdu_start); end
        checks++;
        if (bus.mdu_busy !== 1'b0) begin errors++; $display("FAIL rel_busy0: got %b want 0", bus.mdu_busy); end
        for (int k = 1; k <= 6; k++) begin
            tick();
            drive(MD_NONE, MD_NONE, 1'b0);
            checks++;
            if (bus.mdu_busy !== (k <= 5)) begin errors++; $display("FAIL rel_busy k=%0d: got %b want %b", k, bus.mdu_busy, (k <= 5)); end
            checks++;
            if (bus.mdu_hilo_we !== (k == 5)) begin errors++; $display("FAIL rel_hilo k=%0d: got %b want %b", k, bus.mdu_hilo_we, (k == 5)); end
        end
        $display("txn reset+mult: done");
    endtask

    task automatic test_div_stall();
        tick();
        drive(MD_MFLO, MD_DIV, 1'b0);
        checks++;
        if (bus.mdu_start !== 1'b1) begin errors++; $display("FAIL div_start: got %b want 1", bus.mdu_start); end
        checks++;
        if (bus.md_stall !== 1'b1) begin errors++; $display("FAIL div_stall T: got %b want 1", bus.md_stall); end
        for (int k = 1; k <= 10; k++) begin
            tick();
            drive(MD_MFLO, MD_NONE, 1'b0);
            checks++;
            if (bus.md_stall !== 1'b1) begin errors++; $display("FAIL div_stall k=%0d: got %b want 1", k, bus.md_stall); end
            checks++;
            if (bus.mdu_hilo_we !== (k == 10)) begin errors++; $display("FAIL div_hilo k=%0d: got %b want %b", k, bus.mdu_hilo_we, (k == 10)); end
        end
        tick();
        drive(MD_MFLO, MD_NONE, 1'b0);
        checks++;
        if (bus.md_stall !== 1'b0) begin errors++; $display("FAIL div_stall_end: got %b want 0", bus.md_stall); end
        checks++;
        if (bus.mdu_busy !== 1'b0) begin errors++; $display("FAIL div_busy_end: got %b want 0", bus.mdu_busy); end
        $display("txn div with mflo in D: done");
    endtask

    task automatic test_mthi();
        tick();
        drive(MD_MFHI, MD_MTHI, 1'b0);
        checks++;
        if (bus.mdu_start !== 1'b0) begin errors++; $display("FAIL mthi_start: got %b want 0", bus.mdu_start); end
        checks++;
        if (bus.md_stall !== 1'b0) begin errors++; $display("FAIL mthi_stall: got %b want 0", bus.md_stall); end
        tick();
        drive(MD_NONE, MD_NONE, 1'b0);
        checks++;
        if (bus.mdu_busy !== 1'b0) begin errors++; $display("FAIL mthi_busy: got %b want 0", bus.mdu_busy); end
        $display("txn mthi/mfhi: done");
    endtask

    task automatic test_mult_nostall();
        tick();
        drive(MD_NONE, MD_MULT, 1'b0);
        checks++;
        if (bus.md_stall !== 1'b0) begin errors++; $display("FAIL ns_stall T: got %b want 0", bus.md_stall); end
        for (int k = 1; k <= 6; k++) begin
            tick();
            drive(MD_NONE, MD_NONE, 1'b0);
            checks++;
            if (bus.md_stall !== 1'b0) begin errors++; $display("FAIL ns_stall k=%0d: got %b want 0", k, bus.md_stall); end
            checks++;
            if (bus.mdu_busy !== (k <= 5)) begin errors++; $display("FAIL ns_busy k=%0d: got %b want %b", k, bus.mdu_busy, (k <= 5)); end
            checks++;
            if (bus.mdu_hilo_we !== (k == 5)) begin errors++; $display("FAIL ns_hilo k=%0d: got %b want %b", k, bus.mdu_hilo_we, (k == 5)); end
        end
        $display("txn mult with add stream: done");
    endtask

    task automatic test_back_to_back();
        tick();
        drive(MD_DIV, MD_MULT, 1'b0);
        checks++;
        if (bus.md_stall !== 1'b1) begin errors++; $display("FAIL b2b_stall T: got %b want 1", bus.md_stall); end
        for (int k = 1; k <= 5; k++) begin
            tick();
            drive(MD_DIV, MD_NONE, 1'b0);
            checks++;
            if (bus.md_stall !== 1'b1) begin errors++; $display("FAIL b2b_stall k=%0d: got %b want 1", k, bus.md_stall); end
        end
        tick();
        drive(MD_NONE, MD_DIV, 1'b0);
        checks++;
        if (bus.mdu_start !== 1'b1) begin errors++; $display("FAIL b2b_start2: got %b want 1", bus.mdu_start); end
        checks++;
        if (bus.mdu_busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_gap: got %b want 0", bus.mdu_busy); end
        for (int k = 1; k <= 11; k++) begin
            tick();
            drive(MD_NONE, MD_NONE, 1'b0);
            checks++;
            if (bus.mdu_busy !== (k <= 10)) begin errors++; $display("FAIL b2b_busy k=%0d: got %b want %b", k, bus.mdu_busy, (k <= 10)); end
            checks++;
            if (bus.mdu_hilo_we !== (k == 10)) begin errors++; $display("FAIL b2b_hilo k=%0d: got %b want %b", k, bus.mdu_hilo_we, (k == 10)); end
        end
        $display("txn mult then div back-to-back: done");
    endtask

    task automatic test_reset_mid();
        tick();
        drive(MD_NONE, MD_DIVU, 1'b0);
        checks++;
        if (bus.mdu_start !== 1'b1) begin errors++; $display("FAIL mid_start: got %b want 1", bus.mdu_start); end
        for (int k = 1; k <= 2; k++) begin
            tick();
            drive(MD_NONE, MD_NONE, 1'b0);
            checks++;
            if (bus.mdu_busy !== 1'b1) begin errors++; $display("FAIL mid_busy k=%0d: got %b want 1", k, bus.mdu_busy); end
        end
        tick();
        reset = 1'b0;
        drive(MD_NONE, MD_NONE, 1'b0);
        checks++;
        if (bus.mdu_busy !== 1'b1) begin errors++; $display("FAIL mid_busy T+3: got %b want 1", bus.mdu_busy); end
        tick();
        reset = 1'b1;
        drive(MD_NONE, MD_NONE, 1'b0);
        checks++;
        if (bus.mdu_busy !== 1'b0) begin errors++; $display("FAIL mid_busy_cleared: got %b want 0", bus.mdu_busy); end
        for (int k = 1; k <= 12; k++) begin
            tick();
            drive(MD_NONE, MD_NONE, 1'b0);
            checks++;
            if (bus.mdu_hilo_we !== 1'b0 || bus.mdu_busy !== 1'b0) begin
                errors++;
                $display("FAIL mid_after k=%0d: hilo=%b busy=%b want 0/0", k, bus.mdu_hilo_we, bus.mdu_busy);
            end
        end
        $display("txn div aborted by reset: done");
    endtask

    task automatic test_cancel();
        tick();
        drive(MD_MULT, MD_MULTU, 1'b1);
`ifdef MDU_CANCEL_EN
        checks++;
        if (bus.mdu_start !== 1'b0) begin errors++; $display("FAIL cancel_start: got %b want 0", bus.mdu_start); end
        checks++;
        if (bus.md_stall !== 1'b0) begin errors++; $display("FAIL cancel_stall: got %b want 0", bus.md_stall); end
        for (int k = 1; k <= 6; k++) begin
            tick();
            drive(MD_NONE, MD_NONE, 1'b0);
            checks++;
            if (bus.mdu_busy !== 1'b0) begin errors++; $display("FAIL cancel_busy k=%0d: got %b want 0", k, bus.mdu_busy); end
        end
`else
        checks++;
        if (bus.mdu_start !== 1'b1) begin errors++; $display("FAIL nocancel_start: got %b want 1", bus.mdu_start); end
        checks++;
        if (bus.md_stall !== 1'b1) begin errors++; $display("FAIL nocancel_stall: got %b want 1", bus.md_stall); end
        for (int k = 1; k <= 6; k++) begin
            tick();
            drive(MD_NONE, MD_NONE, 1'b0);
            checks++;
            if (bus.mdu_busy !== (k <= 5)) begin errors++; $display("FAIL nocancel_busy k=%0d: got %b want %b", k, bus.mdu_busy, (k <= 5)); end
        end
`endif
        $display("txn multu with e_cancel: done");
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b0;
        bus.d_md_op  = MD_NONE;
        bus.e_md_op  = MD_NONE;
        bus.e_cancel = 1'b0;
        test_reset();
        test_div_stall();
        test_mthi();
        test_mult_nostall();
        test_back_to_back();
        test_reset_mid();
        test_cancel();
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
